// File: rtl/fsm_2_if.sv
// Sensor/actuator bundle for the two-sensor sequencing controller.
// The controller takes the slave side; the sensor/actuator environment takes the master side.
`timescale 1ns/100ps
interface fsm_2_if;
  logic S1;
  logic S2;
  logic A;
  logic C;

  modport master (output S1, output S2, input A, input C);
  modport slave  (input S1, input S2, output A, output C);
endinterface

// File: rtl/fsm_2.sv
// Two-sensor sequencing controller: S1 edge starts A, S2 edge or timeout moves to a fixed C phase.
// Sensors are synchronised and acted on only at their rising edges.
`timescale 1ns/100ps
module fsm_2 #(
  parameter int unsigned A_TIMEOUT = 16,
  parameter int unsigned C_HOLD    = 4
) (
  input logic    clk,
  input logic    rst_n,
  fsm_2_if.slave bus
);

  localparam logic [15:0] ATimeoutLast = 16'(A_TIMEOUT - 1);
  localparam logic [15:0] CHoldLast    = 16'(C_HOLD - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StA    = 2'd1,
    StC    = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d, cnt_inc;
  logic        a_q, c_q;

  logic s1_sync1_q, s1_sync2_q, s1_prev_q;
  logic s2_sync1_q, s2_sync2_q, s2_prev_q;
  logic rise_s1, rise_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_sync1_q <= 1'b0;
      s1_sync2_q <= 1'b0;
      s1_prev_q  <= 1'b0;
      s2_sync1_q <= 1'b0;
      s2_sync2_q <= 1'b0;
      s2_prev_q  <= 1'b0;
    end else begin
      s1_sync1_q <= bus.S1;
      s1_sync2_q <= s1_sync1_q;
      s1_prev_q  <= s1_sync2_q;
      s2_sync1_q <= bus.S2;
      s2_sync2_q <= s2_sync1_q;
      s2_prev_q  <= s2_sync2_q;
    end
  end

  assign rise_s1 = s1_sync2_q & ~s1_prev_q;
  assign rise_s2 = s2_sync2_q & ~s2_prev_q;

  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_inc;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        // S1 wins over a simultaneous S2; that S2 edge is simply dropped.
        if (rise_s1) begin
          state_d = StA;
        end
      end
      StA: begin
        if (rise_s2 || (cnt_q == ATimeoutLast)) begin
          state_d = StC;
          cnt_d   = '0;
        end
      end
      StC: begin
        if (cnt_q == CHoldLast) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= (state_d == StA);
      c_q     <= (state_d == StC);
    end
  end

  assign bus.A = a_q;
  assign bus.C = c_q;

endmodule

// File: tb/tb_fsm_2.sv
// Directed self-checking bench for fsm_2 (A_TIMEOUT=16, C_HOLD=4, clock period 2).
// Inputs change just after the falling edge; outputs are sampled at the falling edge.
`timescale 1ns/100ps
module tb_fsm_2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  fsm_2_if bus_if ();

  fsm_2 #(
    .A_TIMEOUT(16),
    .C_HOLD   (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #1 clk = ~clk;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_a"}, int'(bus_if.A), 0);
    check_eq({tag, "_c"}, int'(bus_if.C), 0);
  endtask

  // Counts consecutive samples (starting now) with the chosen output high; bounded.
  task automatic count_high(input bit sel_c, output int n);
    n = 0;
    while (((sel_c ? bus_if.C : bus_if.A) === 1'b1) && (n < 200)) begin
      n++;
      step();
    end
  endtask

  int n;
  int starts;
  logic a_prev;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    bus_if.S1 = 1'b1;
    bus_if.S2 = 1'b1;
    #0.2 rst_n = 1'b0;
    #0.2 check_idle("rst_async");

    // Reset held with both sensors high.
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("rst_hold");
    end
    bus_if.S1 = 1'b0;
    bus_if.S2 = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("rst_release");
    end

    // Basic S1 ... S2 sequence.
    bus_if.S1 = 1'b1;
    step();
    step();
    check_eq("basic_a_early", int'(bus_if.A), 0);
    bus_if.S1 = 1'b0;
    step();
    check_eq("basic_a_rise", int'(bus_if.A), 1);
    step();
    step();
    step();
    bus_if.S2 = 1'b1;
    step();
    step();
    check_eq("basic_a_hold", int'(bus_if.A), 1);
    bus_if.S2 = 1'b0;
    step();
    check_eq("basic_a_end", int'(bus_if.A), 0);
    check_eq("basic_c_start", int'(bus_if.C), 1);
    count_high(1'b1, n);
    check_eq("basic_c_len", n, 4);
    check_idle("basic_done");

    // Timeout with no S2.
    bus_if.S1 = 1'b1;
    step();
    bus_if.S1 = 1'b0;
    step();
    step();
    check_eq("to_a_rise", int'(bus_if.A), 1);
    count_high(1'b0, n);
    check_eq("to_a_len", n, 16);
    check_eq("to_c_start", int'(bus_if.C), 1);
    count_high(1'b1, n);
    check_eq("to_c_len", n, 4);
    check_idle("to_done");

    // S2 alone in IDLE is ignored.
    bus_if.S2 = 1'b1;
    step();
    bus_if.S2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle("s2_idle");
    end

    // S1 during ST_A and ST_C neither retriggers nor extends.
    bus_if.S1 = 1'b1;
    step();
    bus_if.S1 = 1'b0;
    step();
    step();
    check_eq("ign_a_rise", int'(bus_if.A), 1);
    bus_if.S1 = 1'b1;
    step();
    bus_if.S1 = 1'b0;
    count_high(1'b0, n);
    check_eq("ign_a_len", n, 15);
    check_eq("ign_c_start", int'(bus_if.C), 1);
    bus_if.S1 = 1'b1;
    step();
    bus_if.S1 = 1'b0;
    count_high(1'b1, n);
    check_eq("ign_c_len", n, 3);
    for (int i = 0; i < 6; i++) begin
      step();
      check_idle("ign_after");
    end

    // S1 held for 50 cycles gives one sequence only.
    starts = 0;
    a_prev = bus_if.A;
    bus_if.S1 = 1'b1;
    for (int i = 0; i < 50; i++) begin
      step();
      if (bus_if.A && !a_prev) starts++;
      a_prev = bus_if.A;
    end
    check_eq("held_starts", starts, 1);
    check_idle("held_end");
    bus_if.S1 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check_idle("held_release");

    // Simultaneous S1/S2 in IDLE: A runs its full length.
    bus_if.S1 = 1'b1;
    bus_if.S2 = 1'b1;
    step();
    bus_if.S1 = 1'b0;
    bus_if.S2 = 1'b0;
    step();
    step();
    check_eq("sim_a_rise", int'(bus_if.A), 1);
    count_high(1'b0, n);
    check_eq("sim_a_len", n, 16);
    count_high(1'b1, n);
    check_eq("sim_c_len", n, 4);

    // Simultaneous start, then a later separate S2 ends A.
    bus_if.S1 = 1'b1;
    bus_if.S2 = 1'b1;
    step();
    bus_if.S1 = 1'b0;
    bus_if.S2 = 1'b0;
    step();
    step();
    check_eq("sim2_a_rise", int'(bus_if.A), 1);
    for (int i = 0; i < 4; i++) step();
    bus_if.S2 = 1'b1;
    step();
    bus_if.S2 = 1'b0;
    step();
    check_eq("sim2_a_hold", int'(bus_if.A), 1);
    step();
    check_eq("sim2_a_end", int'(bus_if.A), 0);
    check_eq("sim2_c_start", int'(bus_if.C), 1);
    count_high(1'b1, n);
    check_eq("sim2_c_len", n, 4);

    // Async reset mid-C, released with S1 still high.
    bus_if.S1 = 1'b1;
    step();
    bus_if.S1 = 1'b0;
    step();
    step();
    bus_if.S2 = 1'b1;
    step();
    bus_if.S2 = 1'b0;
    step();
    step();
    check_eq("ar_c_on", int'(bus_if.C), 1);
    step();
    #0.5;
    rst_n = 1'b0;
    bus_if.S1 = 1'b1;
    #0.2 check_idle("ar_async");
    step();
    step();
    check_idle("ar_hold");
    rst_n = 1'b1;
    step();
    step();
    check_eq("ar_a_early", int'(bus_if.A), 0);
    step();
    check_eq("ar_a_restart", int'(bus_if.A), 1);
    bus_if.S1 = 1'b0;
    count_high(1'b0, n);
    check_eq("ar_a_len", n, 16);
    count_high(1'b1, n);
    check_eq("ar_c_len", n, 4);
    check_idle("ar_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_2.md
# fsm_2

Two-sensor sequencing controller for the warehouse control path. It drives two actuator outputs from two sensor inputs. Sensor S1 starts actuator A. Sensor S2, or a timeout, ends A and starts a fixed-length actuator C phase, after which the block returns to idle. Sensor inputs are asynchronous to the clock, so the block synchronises them and acts only on their rising edges.

## Interface
- A_TIMEOUT, default 16: maximum cycles in ST_A before a forced move to ST_C; range 1..65535.
- C_HOLD, default 4: number of cycles C stays asserted; range 1..65535.
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset, asynchronous, active-low.
- S1  input  1  start sensor, asynchronous level.
- S2  input  1  stop sensor, asynchronous level.
- A  output  1  actuator A enable, registered.
- C  output  1  actuator C enable, registered.

## Operation
- Input conditioning:
  - S1 and S2 each pass through a 2-flop synchroniser, then a third "previous" flop.
  - rise_S1 = sync2_S1 & ~prev_S1. rise_S2 is formed the same way.
  - A level held high produces only one event.
- States, 2-bit encoding:
  - IDLE = 0: A=0, C=0.
  - ST_A = 1: A=1, C=0.
  - ST_C = 2: A=0, C=1.
  - Encoding 3 is illegal and returns to IDLE on the next clock.
- Transitions:
  - IDLE: rise_S1 → ST_A, cnt cleared. rise_S2 alone is ignored.
  - IDLE with rise_S1 and rise_S2 in the same cycle: S1 wins → ST_A. That S2 edge is discarded.
  - ST_A: rise_S2 → ST_C, cnt cleared.
  - ST_A: cnt == A_TIMEOUT-1 with no rise_S2 → ST_C, cnt cleared.
  - ST_A otherwise: cnt increments.
  - ST_A ignores rise_S1.
  - ST_C: cnt == C_HOLD-1 → IDLE. Otherwise cnt increments.
  - ST_C ignores both sensor edges.
- Counter: one shared 16-bit up-counter, cnt. It is cleared on every state change and saturates, never wraps.
- A and C are flops loaded with the decoded next state. They are never both 1.

## Timing
- Reset (rst_n=0) immediately forces these values without waiting for a clock:
  - state=IDLE, cnt=0, A=0, C=0.
  - All synchroniser and prev flops = 0.
- Release of rst_n is used synchronously. The first state change is possible on the third rising edge after release.
- Sensor latency: let E0 be the first rising edge that samples S1=1.
  - sync2 = 1 after E1; rise_S1 is valid between E1 and E2.
  - State and A update on E2. Minimum S1→A latency is 3 edges, including E0.
  - S2→C latency is identical.
- Minimum pulse width for detection: 1 full clock period. Narrower pulses may be missed.
- Length of A:
  - Ends on the edge after rise_S2 is seen.
  - If no S2 arrives, A is high for exactly A_TIMEOUT cycles.
- C is high for exactly C_HOLD cycles, then the block is in IDLE with A=C=0.
- Back-to-back: an S1 edge seen on the cycle IDLE is entered is acted on. It is not lost.
- Reset mid-operation from ST_A or ST_C: A and C drop immediately. Any pending edge history is cleared, so an S1 still held high at release produces a new edge.

## Test plan
- Reset, clk period 2:
  - Stimulus: hold rst_n=0 with S1=S2=1.
  - Required: A=0, C=0 throughout.
  - Then release with S1=S2=0. Required: state stays IDLE.
- Basic sequence:
  - Stimulus: S1=1 at t=5, S1=0 at t=10, S2=1 at t=15, S2=0 at t=20.
  - Required: A rises 3 edges after S1 is sampled, and stays 1 until 3 edges after S2 is sampled.
  - Then C=1 for exactly 4 cycles, then A=C=0.
- Timeout:
  - Stimulus: S1 pulse, no S2.
  - Required: A high exactly 16 cycles, then C high 4 cycles, then IDLE.
- Ignored edges:
  - Stimulus: S2 pulse in IDLE. Required: no output change.
  - Stimulus: S1 pulse during ST_A and ST_C. Required: no retrigger and no extension.
  - Stimulus: S1 held high for 50 cycles. Required: only one A/C sequence.
- Simultaneous S1 and S2 rising in IDLE:
  - Required: ST_A entered, and A is not cut short by that S2.
  - A later separate S2 moves the block to ST_C.
- Async reset:
  - Stimulus: assert rst_n=0 mid-C phase, between clock edges.
  - Required: C=0 before the next edge.
  - Stimulus: release with S1=1 held. Required: a new A sequence starts 3 edges later.
